// File: rtl/serial_subtractor.sv
// Bit-serial borrow-ripple subtractor: d = a - b - bin, one bit per clock, LSB first.
// Start/busy/done handshake; d and bout change only on the completion edge.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             diff_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // One full-subtractor cell acting on the current LSBs of the operand shifters.
  assign diff_bit = a_sh[0] ^ b_sh[0] ^ br;
  assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  // Difference bits enter at the MSB so the final bit lands the word in place.
  assign res_next = {diff_bit, res_sh[WIDTH-1:1]};

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= StRun;
          end
        end
        StRun: begin
          // start is deliberately ignored here.
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          br     <= br_next;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            d     <= res_next;
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            br     <= bin;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with an exhaustive operand sweep.
module tb_serial_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation from IDLE; inputs are scrambled after acceptance.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin_v,
                        input logic [W-1:0] ed, input logic eb, input string tag);
    a     = av;
    b     = bv;
    bin   = bin_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = ~av;
    b     = ~bv;
    bin   = ~bin_v;
    for (int k = 0; k < W; k++) begin
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " done_low"}, 32'(done), 32'd0);
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
    chk({tag, " d"}, 32'(d), 32'(ed));
    chk({tag, " bout"}, 32'(bout), 32'(eb));
    @(negedge clk);
    chk({tag, " done_drop"}, 32'(done), 32'd0);
    chk({tag, " d_hold"}, 32'(d), 32'(ed));
    chk({tag, " bout_hold"}, 32'(bout), 32'(eb));
  endtask

  initial begin
    logic [W:0] ref_v;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst d", 32'(d), 32'd0);
    chk("rst bout", 32'(bout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    run_op(4'b0111, 4'b0101, 1'b0, 4'b0010, 1'b0, "op1");
    run_op(4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b1, "op2");
    run_op(4'b1000, 4'b1001, 1'b0, 4'b1111, 1'b1, "op3");
    run_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, "op4");
    run_op(4'b0011, 4'b0011, 1'b1, 4'b1111, 1'b1, "op5");

    // start while busy is ignored
    a = 4'b0111; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign c1 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign c2 busy", 32'(busy), 32'd1);
    start = 1'b1; a = 4'b1111; b = 4'b0000;
    @(negedge clk);
    start = 1'b0; a = 4'b1001; b = 4'b0110;
    chk("ign c3 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("ign c4 busy", 32'(busy), 32'd1);
    chk("ign c4 done", 32'(done), 32'd0);
    @(negedge clk);
    chk("ign done", 32'(done), 32'd1);
    chk("ign d", 32'(d), 32'b0010);
    chk("ign bout", 32'(bout), 32'd0);
    @(negedge clk);
    chk("ign idle busy", 32'(busy), 32'd0);

    // Back-to-back with start held high
    a = 4'b0011; b = 4'b0001; bin = 1'b0; start = 1'b1;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("b2b first busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b first d", 32'(d), 32'b0010);
    chk("b2b first bout", 32'(bout), 32'd0);
    a = 4'b0001; b = 4'b0011;
    @(negedge clk);
    chk("b2b rebusy", 32'(busy), 32'd1);
    chk("b2b done drop", 32'(done), 32'd0);
    chk("b2b d hold", 32'(d), 32'b0010);
    for (int k = 1; k < W; k++) begin
      @(negedge clk);
      chk("b2b second busy", 32'(busy), 32'd1);
      chk("b2b second no done", 32'(done), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b second d", 32'(d), 32'b1110);
    chk("b2b second bout", 32'(bout), 32'd1);
    @(negedge clk);
    chk("b2b idle busy", 32'(busy), 32'd0);
    chk("b2b idle done", 32'(done), 32'd0);

    // Reset mid-RUN (d currently 1110, bout 1)
    a = 4'b0111; b = 4'b0101; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst d", 32'(d), 32'd0);
    chk("midrst bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      chk("midrst no done", 32'(done), 32'd0);
      chk("midrst no busy", 32'(busy), 32'd0);
    end

    // Exhaustive sweep against an unsigned reference
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          ref_v = {1'b0, 4'(ai)} - {1'b0, 4'(bi)} - 5'(ci);
          run_op(4'(ai), 4'(bi), 1'(ci), ref_v[W-1:0], ref_v[W], "sweep");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
